// File: rtl/vc_tx_scheduler_pkg.sv
// Shared defaults and flit type for the per-VC transmit scheduler.
// Also home of the default VC buffer depth used by the switch output ports.
package vc_tx_scheduler_pkg;

  localparam int DEFAULT_VC_W         = 2;
  localparam int DEFAULT_D_W          = 8;
  localparam int DEFAULT_X_W          = 3;
  localparam int DEFAULT_Y_W          = 3;
  localparam int DEFAULT_VC_BUF_DEPTH = 2;

  typedef struct packed {
    logic [DEFAULT_X_W-1:0] x;
    logic [DEFAULT_Y_W-1:0] y;
    logic [DEFAULT_D_W-1:0] d;
  } vc_flit_t;

  function automatic int occWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vc_tx_scheduler_if.sv
// Ingress ready/valid flit streams (packed per VC) and one-hot DVR egress.
// The scheduler takes the slave view; the upstream/transmitter side takes master.
interface vc_tx_scheduler_if
  import vc_tx_scheduler_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W,
  parameter int D_W  = DEFAULT_D_W,
  parameter int X_W  = DEFAULT_X_W,
  parameter int Y_W  = DEFAULT_Y_W
) ();

  logic [VC_W-1:0]     s_valid;
  logic [VC_W-1:0]     s_ready;
  logic [VC_W*X_W-1:0] s_x;
  logic [VC_W*Y_W-1:0] s_y;
  logic [VC_W*D_W-1:0] s_d;
  logic [VC_W-1:0]     m_v;
  logic [X_W-1:0]      m_x;
  logic [Y_W-1:0]      m_y;
  logic [D_W-1:0]      m_d;
  logic [VC_W-1:0]     m_b;

  modport slave (
    input  s_valid, s_x, s_y, s_d, m_b,
    output s_ready, m_v, m_x, m_y, m_d
  );

  modport master (
    output s_valid, s_x, s_y, s_d, m_b,
    input  s_ready, m_v, m_x, m_y, m_d
  );

endinterface

// File: rtl/vc_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or above ptr_i, wrapping around; zero grant when nothing requests.
module rr_arbiter
  import vc_tx_scheduler_pkg::*;
#(
  parameter int N = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic found;

  // Walk distances from the pointer; the first requester at the smallest distance wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_i[k] &&
            ((int'(ptr_i) + off == k) || (int'(ptr_i) + off == k + N))) begin
          gnt_o[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vc_tx_scheduler.sv
// Per-VC ingress FIFOs feeding a round-robin scheduler that drives the
// credit-based transmitter's one-hot DVR interface.
module vc_tx_scheduler
  import vc_tx_scheduler_pkg::*;
#(
  parameter int VC_W      = DEFAULT_VC_W,
  parameter int D_W       = DEFAULT_D_W,
  parameter int X_W       = DEFAULT_X_W,
  parameter int Y_W       = DEFAULT_Y_W,
  parameter int BUF_DEPTH = DEFAULT_VC_BUF_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  vc_tx_scheduler_if.slave                       bus,
  output logic [VC_W*$clog2(BUF_DEPTH+1)-1:0]    o_occ
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int SEL_W = (VC_W > 1) ? $clog2(VC_W) : 1;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [D_W-1:0] d;
  } flit_t;

  logic [VC_W-1:0]  push, pop, full, empty, eligible, gnt;
  flit_t [VC_W-1:0] head;
  flit_t            selFlit;
  logic [SEL_W-1:0] rrPtr_q, rrPtr_d;

  for (genvar k = 0; k < VC_W; k++) begin : g_vc
    flit_t             mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [OCC_W-1:0]  occ_q;

    assign full[k]  = (occ_q == OCC_W'(BUF_DEPTH));
    assign empty[k] = (occ_q == '0);
    assign push[k]  = bus.s_valid[k] & bus.s_ready[k];
    assign pop[k]   = bus.m_v[k];
    assign head[k]  = mem_q[rdPtr_q];
    assign o_occ[k*OCC_W +: OCC_W] = occ_q;

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
      if (rst) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        occ_q   <= '0;
      end else begin
        if (push[k]) begin
          mem_q[wrPtr_q] <= {bus.s_x[k*X_W +: X_W], bus.s_y[k*Y_W +: Y_W], bus.s_d[k*D_W +: D_W]};
          wrPtr_q        <= wrPtr_q + 1'b1;
        end
        if (pop[k]) begin
          rdPtr_q <= rdPtr_q + 1'b1;
        end
        if (push[k] != pop[k]) begin
          occ_q <= push[k] ? occ_q + 1'b1 : occ_q - 1'b1;
        end
      end
    end
  end

  assign bus.s_ready = ~full & {VC_W{~rst}};
  assign eligible    = ~empty & ~bus.m_b;

  rr_arbiter #(.N(VC_W)) u_arb (
    .req_i (eligible),
    .ptr_i (rrPtr_q),
    .gnt_o (gnt)
  );

  assign bus.m_v = rst ? '0 : gnt;

  always_comb begin
    selFlit = '0;
    rrPtr_d = rrPtr_q;
    for (int k = 0; k < VC_W; k++) begin
      if (bus.m_v[k]) begin
        selFlit = flit_t'(selFlit | head[k]);
        rrPtr_d = (k == VC_W - 1) ? '0 : SEL_W'(k + 1);
      end
    end
  end

  assign bus.m_x = selFlit.x;
  assign bus.m_y = selFlit.y;
  assign bus.m_d = selFlit.d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

  a_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(bus.m_v));
  a_noBpGrant: assert property (@(posedge clk) disable iff (rst) (bus.m_v & bus.m_b) == '0);
  a_noOvf:     assert property (@(posedge clk) disable iff (rst) (push & full) == '0);
  a_noUnf:     assert property (@(posedge clk) disable iff (rst) (pop & empty) == '0);
  a_known:     assert property (@(posedge clk) disable iff (rst) !$isunknown({bus.m_v, bus.s_ready, bus.m_b}));
  a_dataKnown: assert property (@(posedge clk) disable iff (rst) (|bus.m_v) |-> !$isunknown(bus.m_d));

endmodule

// File: tb/tb_vc_tx_scheduler.sv
// Bench for vc_tx_scheduler: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based model.
module tb_vc_tx_scheduler;
  import vc_tx_scheduler_pkg::*;

  localparam int VC_W  = DEFAULT_VC_W;
  localparam int X_W   = DEFAULT_X_W;
  localparam int Y_W   = DEFAULT_Y_W;
  localparam int D_W   = DEFAULT_D_W;
  localparam int DEPTH = DEFAULT_VC_BUF_DEPTH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [VC_W*OCC_W-1:0] occ;

  always #5 clk = ~clk;

  vc_tx_scheduler_if #(.VC_W(VC_W), .D_W(D_W), .X_W(X_W), .Y_W(Y_W)) bus ();

  vc_tx_scheduler #(
    .VC_W(VC_W), .D_W(D_W), .X_W(X_W), .Y_W(Y_W), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .o_occ (occ)
  );

  typedef struct { int x; int y; int d; } mFlit_t;

  typedef struct {
    string      name;
    logic       r;
    logic [1:0] v, b;
    logic [7:0] d0, d1;
    logic [2:0] x1, y1;
    logic [1:0] expV, expReady;
    logic [7:0] expD;
    logic [2:0] expX, expY;
    logic [3:0] expOcc;
  } vec_t;

  mFlit_t          modelQ [VC_W][$];
  int              modelPtr = 0;
  int              checks   = 0;
  int              failures = 0;
  logic            curRst   = 1'b1;
  logic [VC_W-1:0] curValid = '0;
  logic [VC_W-1:0] curMb    = '0;
  logic [X_W-1:0]  curX [VC_W];
  logic [Y_W-1:0]  curY [VC_W];
  logic [D_W-1:0]  curD [VC_W];

  task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the sampling edge.
  task automatic applyStimulus(input logic r, input logic [VC_W-1:0] v, input logic [VC_W-1:0] b);
    curRst = r;  curValid = v;  curMb = b;
    rst = r;  bus.s_valid = v;  bus.m_b = b;
    for (int k = 0; k < VC_W; k++) begin
      bus.s_x[k*X_W +: X_W] = curX[k];
      bus.s_y[k*Y_W +: Y_W] = curY[k];
      bus.s_d[k*D_W +: D_W] = curD[k];
    end
    @(negedge clk);
  endtask

  function automatic int modelGrant();
    if (curRst) return -1;
    for (int i = 0; i < VC_W; i++) begin
      int k = (modelPtr + i) % VC_W;
      if (modelQ[k].size() > 0 && !curMb[k]) return k;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag);
    int g = modelGrant();
    logic [VC_W-1:0] expV = '0;
    logic [VC_W-1:0] expReady;
    logic [VC_W*OCC_W-1:0] expOcc;
    int ex = 0, ey = 0, ed = 0;
    for (int k = 0; k < VC_W; k++) begin
      expReady[k] = !curRst && (modelQ[k].size() < DEPTH);
      expOcc[k*OCC_W +: OCC_W] = OCC_W'(modelQ[k].size());
    end
    if (g >= 0) begin
      expV[g] = 1'b1;
      ex = modelQ[g][0].x;  ey = modelQ[g][0].y;  ed = modelQ[g][0].d;
    end
    expectEq({tag, " m_v"},     bus.m_v,     expV);
    expectEq({tag, " m_x"},     bus.m_x,     64'(ex));
    expectEq({tag, " m_y"},     bus.m_y,     64'(ey));
    expectEq({tag, " m_d"},     bus.m_d,     64'(ed));
    expectEq({tag, " s_ready"}, bus.s_ready, expReady);
    expectEq({tag, " o_occ"},   occ,         expOcc);
  endtask

  // Advance the model across the clock edge using the inputs held this cycle.
  task automatic finishCycle();
    int g = modelGrant();
    bit canPush [VC_W];
    for (int k = 0; k < VC_W; k++) canPush[k] = modelQ[k].size() < DEPTH;
    @(posedge clk);
    if (curRst) begin
      for (int k = 0; k < VC_W; k++) modelQ[k].delete();
      modelPtr = 0;
    end else begin
      if (g >= 0) begin
        void'(modelQ[g].pop_front());
        modelPtr = (g + 1) % VC_W;
      end
      for (int k = 0; k < VC_W; k++) begin
        if (curValid[k] && canPush[k])
          modelQ[k].push_back('{x: int'(curX[k]), y: int'(curY[k]), d: int'(curD[k])});
      end
    end
    #1;
  endtask

  task automatic runCycle(input logic r, input logic [VC_W-1:0] v, input logic [VC_W-1:0] b, input string tag);
    applyStimulus(r, v, b);
    checkOutput(tag);
    finishCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs [13];
    for (int k = 0; k < VC_W; k++) begin
      curX[k] = '0;  curY[k] = '0;  curD[k] = '0;
    end
    bus.s_valid = '0;  bus.m_b = '0;  bus.s_x = '0;  bus.s_y = '0;  bus.s_d = '0;

    //          name        r  v      b      d0     d1     x1 y1 | expV   rdy    expD   eX eY occ
    vecs[0]  = '{"rst0",     1, 2'b11, 2'b00, 8'h00, 8'h00, 0, 0,  2'b00, 2'b00, 8'h00, 0, 0, 4'b0000};
    vecs[1]  = '{"rst1",     1, 2'b11, 2'b00, 8'h00, 8'h00, 0, 0,  2'b00, 2'b00, 8'h00, 0, 0, 4'b0000};
    vecs[2]  = '{"rst2",     1, 2'b11, 2'b00, 8'h00, 8'h00, 0, 0,  2'b00, 2'b00, 8'h00, 0, 0, 4'b0000};
    vecs[3]  = '{"post_rst", 0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,  2'b00, 2'b11, 8'h00, 0, 0, 4'b0000};
    vecs[4]  = '{"lat_push", 0, 2'b10, 2'b00, 8'h00, 8'hA5, 1, 2,  2'b00, 2'b11, 8'h00, 0, 0, 4'b0000};
    vecs[5]  = '{"lat_out",  0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,  2'b10, 2'b11, 8'hA5, 1, 2, 4'b0100};
    vecs[6]  = '{"lat_idle", 0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,  2'b00, 2'b11, 8'h00, 0, 0, 4'b0000};
    vecs[7]  = '{"fair0",    0, 2'b11, 2'b00, 8'h01, 8'h02, 0, 0,  2'b00, 2'b11, 8'h00, 0, 0, 4'b0000};
    vecs[8]  = '{"fair1",    0, 2'b11, 2'b00, 8'h03, 8'h04, 0, 0,  2'b01, 2'b11, 8'h01, 0, 0, 4'b0101};
    vecs[9]  = '{"fair2",    0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,  2'b10, 2'b01, 8'h02, 0, 0, 4'b1001};
    vecs[10] = '{"fair3",    0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,  2'b01, 2'b11, 8'h03, 0, 0, 4'b0101};
    vecs[11] = '{"fair4",    0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,  2'b10, 2'b11, 8'h04, 0, 0, 4'b0100};
    vecs[12] = '{"fair5",    0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0,  2'b00, 2'b11, 8'h00, 0, 0, 4'b0000};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      curD[0] = vecs[i].d0;  curD[1] = vecs[i].d1;
      curX[0] = '0;          curY[0] = '0;
      curX[1] = vecs[i].x1;  curY[1] = vecs[i].y1;
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].b);
      expectEq({vecs[i].name, " tbl m_v"},     bus.m_v,     vecs[i].expV);
      expectEq({vecs[i].name, " tbl s_ready"}, bus.s_ready, vecs[i].expReady);
      expectEq({vecs[i].name, " tbl m_d"},     bus.m_d,     vecs[i].expD);
      expectEq({vecs[i].name, " tbl m_x"},     bus.m_x,     vecs[i].expX);
      expectEq({vecs[i].name, " tbl m_y"},     bus.m_y,     vecs[i].expY);
      expectEq({vecs[i].name, " tbl o_occ"},   occ,         vecs[i].expOcc);
      checkOutput(vecs[i].name);
      finishCycle();
    end

    // Backpressure on VC0 only: VC1 drains, VC0 fills and then releases in order.
    curX[0] = '0;  curY[0] = '0;  curX[1] = '0;  curY[1] = '0;
    curD[0] = 8'h01;  curD[1] = 8'h11;
    runCycle(1'b0, 2'b11, 2'b01, "bp_a");
    curD[0] = 8'h02;
    applyStimulus(1'b0, 2'b01, 2'b01);
    checkOutput("bp_b");
    expectEq("bp_only_vc1", bus.m_v, 2'b10);
    finishCycle();
    applyStimulus(1'b0, 2'b00, 2'b01);
    checkOutput("bp_c");
    expectEq("bp_occ0_full",  occ[OCC_W-1:0], 2);
    expectEq("bp_ready0_low", bus.s_ready[0], 1'b0);
    expectEq("bp_vc0_held",   bus.m_v, 2'b00);
    finishCycle();
    applyStimulus(1'b0, 2'b00, 2'b00);
    checkOutput("bp_d");
    expectEq("bp_release_v", bus.m_v, 2'b01);
    expectEq("bp_release_d", bus.m_d, 8'h01);
    finishCycle();
    applyStimulus(1'b0, 2'b00, 2'b00);
    checkOutput("bp_e");
    expectEq("bp_order_v", bus.m_v, 2'b01);
    expectEq("bp_order_d", bus.m_d, 8'h02);
    finishCycle();

    // Full throughput on a single VC.
    for (int i = 0; i < 6; i++) begin
      curD[0] = 8'(8'h30 + i);
      applyStimulus(1'b0, 2'b01, 2'b00);
      checkOutput("thru");
      if (i > 0) begin
        expectEq("thru_v",     bus.m_v, 2'b01);
        expectEq("thru_d",     bus.m_d, 8'(8'h30 + i - 1));
        expectEq("thru_occ0",  occ[OCC_W-1:0], 1);
        expectEq("thru_ready", bus.s_ready[0], 1'b1);
      end
      finishCycle();
    end
    runCycle(1'b0, 2'b00, 2'b00, "thru_drain");

    // Mid-traffic reset discards everything buffered.
    curD[0] = 8'hE0;  curD[1] = 8'hE1;
    runCycle(1'b0, 2'b11, 2'b11, "mr_load0");
    curD[0] = 8'hE2;  curD[1] = 8'hE3;
    runCycle(1'b0, 2'b11, 2'b11, "mr_load1");
    applyStimulus(1'b1, 2'b11, 2'b00);
    checkOutput("mr_rst");
    expectEq("mr_rst_v",     bus.m_v, 2'b00);
    expectEq("mr_rst_ready", bus.s_ready, 2'b00);
    finishCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b00, 2'b00);
      checkOutput("mr_after");
      expectEq("mr_after_v",   bus.m_v, 2'b00);
      expectEq("mr_after_d",   bus.m_d, 8'h00);
      expectEq("mr_after_occ", occ, '0);
      finishCycle();
    end

    // Random traffic with occasional backpressure bursts and resets.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < VC_W; k++) begin
        curX[k] = X_W'($urandom);
        curY[k] = Y_W'($urandom);
        curD[k] = D_W'($urandom);
      end
      runCycle($urandom_range(0, 63) == 0,
               VC_W'($urandom),
               ($urandom_range(0, 2) == 0) ? VC_W'($urandom) : '0,
               "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_tx_scheduler.md
Name: vc_tx_scheduler

Overview:
- Per-VC ingress buffering plus round-robin VC scheduler in front of the credit-based transmitter on each switch output port.
- Accepts independent ready/valid flit streams per VC and buffers each in a small FIFO.
- Each cycle, selects at most one VC that has a buffered flit and no backpressure, then drives the transmitter's one-hot DVR interface (valid/x/y/data in, per-VC backpressure out).

Parameters:
- VC_W, DEFAULT_VC_W: number of virtual channels.
- D_W, DEFAULT_D_W: payload width.
- X_W, DEFAULT_X_W: x-address width.
- Y_W, DEFAULT_Y_W: y-address width.
- BUF_DEPTH, 2: entries per VC FIFO; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  VC_W  per-VC flit offer.
- s_ready  out  VC_W  per-VC accept; a flit transfers when s_valid[k] & s_ready[k].
- s_x  in  VC_W*X_W  per-VC destination x, packed, VC0 in the LSBs.
- s_y  in  VC_W*Y_W  per-VC destination y, packed.
- s_d  in  VC_W*D_W  per-VC payload, packed.
- m_v  out  VC_W  one-hot0 valid to the transmitter.
- m_x  out  X_W  x of the granted flit.
- m_y  out  Y_W  y of the granted flit.
- m_d  out  D_W  payload of the granted flit.
- m_b  in  VC_W  per-VC backpressure from the transmitter (1 = no credit).
- o_occ  out  VC_W*$clog2(BUF_DEPTH+1)  per-VC FIFO occupancy, for debug and perf counters.

Behaviour:
- Reset, while rst is high and on the first cycle after it:
  - all FIFOs empty, o_occ = 0, m_v = 0.
  - s_ready = 0 while rst is high, all ones on the first cycle after.
  - round-robin pointer = 0.
- s_ready[k] = !full[k]. It is registered-state only, with no combinational path from m_b or s_valid.
- Push: s_valid[k] & s_ready[k] writes {x,y,d} at the tail. The entry becomes visible to the arbiter on the next cycle, so minimum ingress-to-m_v latency is 1 cycle. There is no bypass.
- Eligible[k] = !empty[k] & !m_b[k].
- Arbitration is combinational round-robin over the eligible VCs, searching from the pointer upward with wrap-around. It yields a one-hot grant g, or zero if nothing is eligible.
- m_v = g. m_x/m_y/m_d come from the head of the granted VC. When g = 0, m_x/m_y/m_d = 0.
- Pop: m_v[k] implies the transmitter consumes the flit that cycle, because m_b[k] = 0 is already guaranteed. The head of VC k advances at the clock edge.
- Pointer update: on a grant to VC k, pointer <= (k+1) mod VC_W. With no grant, the pointer holds.
- Simultaneous push and pop on the same VC: occupancy is unchanged. On a full FIFO, push cannot occur because s_ready = 0.
- Read/write pointers are $clog2(BUF_DEPTH) bits and wrap naturally. Full and empty are derived from the occupancy counter.
- A VC whose m_b rises keeps its data buffered and is skipped; the other VCs proceed. When m_b falls, the VC becomes eligible again on that same cycle.
- A synchronous reset mid-traffic discards all buffered flits. m_v drops to 0 in the cycle rst is sampled high.
- Invariants to assert in SIMULATION:
  - m_v is onehot0.
  - (m_v & m_b) == 0.
  - no push when full; no pop when empty.
  - m_v, s_ready and m_b are never unknown out of reset.
  - m_d is known when |m_v.

Decomposition:
- Add to common_pkg: DEFAULT_VC_BUF_DEPTH (= 2).
- Add a typedef vc_flit_t {x, y, d} built from the DEFAULT_* widths. The module parameterises its own local struct to match.
- Sub-module: rr_arbiter (parameter N; inputs req[N] and ptr; output one-hot gnt). It is purely combinational and reusable by the switch port arbiters.
- The per-VC FIFO is an inline generate loop, not a separate module.

Test Plan:
- Reset: hold rst 3 cycles with s_valid = all ones → m_v = 0, s_ready = 0 throughout. On the first cycle after rst falls, s_ready = all ones and o_occ = 0.
- Single VC latency: VC_W = 2, m_b = 0. Push flit (x = 1, y = 2, d = 0xA5) on VC1 at cycle 0 → m_v = 2'b10 with x = 1, y = 2, d = 0xA5 at cycle 1. m_v = 0 at cycle 2.
- Fairness: both VCs continuously valid with m_b = 0 → m_v alternates 01, 10, 01, 10… starting from VC0 after reset. Each VC sustains one flit every 2 cycles.
- Backpressure isolation: m_b = 2'b01 and both VCs loaded → only VC1 is granted. VC0 fills to o_occ = 2 and s_ready[0] = 0. Release m_b → VC0 is granted that same cycle and FIFO order is preserved (d = 1, then 2).
- Full throughput, single VC: VC0 only, m_b = 0, s_valid[0] held high → after a 1-cycle fill, one grant per cycle. o_occ stays at 1 and s_ready stays 1.
- Mid-traffic reset: with both FIFOs non-empty, assert rst for 1 cycle → no m_v during reset or on the cycle after it. None of the pre-reset data ever appears on m_d.
